// File: rtl/vc_wrr_sched_if.sv
// vc_wrr_sched_if: request, weight-edit and grant bundle for vc_wrr_sched.
// The clr_stats/served_cnt pair exists only when WRR_STATS_EN is defined.
interface vc_wrr_sched_if #(
    parameter int WEIGHT_W = 3
);
    logic [3:0] req;
    logic edit_weight;
    logic [1:0] vc_assign;
    logic [WEIGHT_W-1:0] weight_assign;
    logic grant_valid;
    logic [1:0] grant_id;
    logic [WEIGHT_W-1:0] quantum_left;
    logic [WEIGHT_W-1:0] weight_out;
`ifdef WRR_STATS_EN
    logic clr_stats;
    logic [31:0] served_cnt;
    modport master (
        output req, edit_weight, vc_assign, weight_assign, clr_stats,
        input grant_valid, grant_id, quantum_left, weight_out, served_cnt
    );
    modport slave (
        input req, edit_weight, vc_assign, weight_assign, clr_stats,
        output grant_valid, grant_id, quantum_left, weight_out, served_cnt
    );
`else
    modport master (
        output req, edit_weight, vc_assign, weight_assign,
        input grant_valid, grant_id, quantum_left, weight_out
    );
    modport slave (
        input req, edit_weight, vc_assign, weight_assign,
        output grant_valid, grant_id, quantum_left, weight_out
    );
`endif
endinterface

// File: rtl/vc_wrr_sched.sv
// vc_wrr_sched: 4-VC weighted round-robin scheduler owning the per-VC weight table.
// Define WRR_STATS_EN to add clr_stats and the per-VC saturating served_cnt counters.
module vc_wrr_sched #(
    parameter int NUM_VC = 4,
    parameter int WEIGHT_W = 3,
    parameter int DEFAULT_WEIGHT = 1
) (
    input logic clk,
    input logic reset,
    vc_wrr_sched_if.slave bus
);
    typedef enum logic {IDLE, SERVE} state_t;
    state_t state;
    logic [WEIGHT_W-1:0] weight [NUM_VC];
    logic [NUM_VC-1:0] elig;
    logic [1:0] ptr, base, win;
    logic ending, load, found;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_VC; i++) elig[i] = bus.req[i] && weight[i] != '0;
    end

    assign ending = state == SERVE && (bus.quantum_left == '0 || !bus.req[bus.grant_id]);
    assign load = state == IDLE || ending;
    assign base = ending ? bus.grant_id + 2'd1 : ptr;

    // Scan from the far end so the eligible VC nearest to base is the last hit.
    always_comb begin
        found = 1'b0;
        win = base;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            if (elig[base + 2'(k)]) begin
                found = 1'b1;
                win = base + 2'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr <= '0;
            bus.grant_valid <= 1'b0;
            bus.grant_id <= '0;
            bus.quantum_left <= '0;
            bus.weight_out <= '0;
            for (int i = 0; i < NUM_VC; i++) weight[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
        end else begin
            if (bus.edit_weight) weight[bus.vc_assign] <= bus.weight_assign;
            if (ending) ptr <= bus.grant_id + 2'd1;
            if (load && found) begin
                state <= SERVE;
                bus.grant_valid <= 1'b1;
                bus.grant_id <= win;
                bus.weight_out <= weight[win];
                bus.quantum_left <= weight[win] - 1'b1;
            end else if (load) begin
                state <= IDLE;
                bus.grant_valid <= 1'b0;
                bus.quantum_left <= '0;
            end else begin
                bus.quantum_left <= bus.quantum_left - 1'b1;
            end
        end
    end

`ifdef WRR_STATS_EN
    logic [7:0] cnt [NUM_VC];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_VC; i++) cnt[i] <= '0;
        end else if (bus.clr_stats) begin
            for (int i = 0; i < NUM_VC; i++) cnt[i] <= '0;
        end else if (bus.grant_valid && cnt[bus.grant_id] != 8'hff) begin
            cnt[bus.grant_id] <= cnt[bus.grant_id] + 8'd1;
        end
    end

    assign bus.served_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif
endmodule

// File: tb/tb_vc_wrr_sched.sv
// tb_vc_wrr_sched: directed scenarios plus random traffic against a quantum-counting reference model.
module tb_vc_wrr_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;

    vc_wrr_sched_if #(.WEIGHT_W(3)) bus();
    vc_wrr_sched dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int mw[4];
    int mptr, mgid, quota, served, m_wo;
    bit mgv;
`ifdef WRR_STATS_EN
    int mcnt[4];
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a quantum is `quota` words; `served` counts words already completed.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            foreach (mw[i]) mw[i] = 1;
            mptr = 0; mgid = 0; quota = 0; served = 0; m_wo = 0; mgv = 0;
`ifdef WRR_STATS_EN
            foreach (mcnt[i]) mcnt[i] = 0;
`endif
        end else begin : step
            int wpre[4];
            bit pick, got;
            wpre = mw;
            pick = !mgv;
            got = 0;
`ifdef WRR_STATS_EN
            if (bus.clr_stats) foreach (mcnt[i]) mcnt[i] = 0;
            else if (mgv && mcnt[mgid] < 255) mcnt[mgid]++;
`endif
            if (mgv) begin
                served++;
                if (served == quota || !bus.req[mgid]) begin
                    pick = 1;
                    mptr = (mgid + 1) % 4;
                end
            end
            if (pick) begin
                for (int k = 0; k < 4; k++) begin
                    if (!got && bus.req[(mptr + k) % 4] && wpre[(mptr + k) % 4] != 0) begin
                        got = 1;
                        mgid = (mptr + k) % 4;
                        quota = wpre[mgid];
                        served = 0;
                        m_wo = quota;
                    end
                end
                mgv = got;
            end
            if (bus.edit_weight) mw[bus.vc_assign] = int'(bus.weight_assign);
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("model_grant_valid", 32'(bus.grant_valid), 32'(mgv));
            chk("model_grant_id", 32'(bus.grant_id), 32'(mgid));
            chk("model_quantum_left", 32'(bus.quantum_left), mgv ? 32'(quota - served - 1) : 32'd0);
            chk("model_weight_out", 32'(bus.weight_out), 32'(m_wo));
`ifdef WRR_STATS_EN
            chk("model_served_cnt", bus.served_cnt, {8'(mcnt[3]), 8'(mcnt[2]), 8'(mcnt[1]), 8'(mcnt[0])});
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        bus.req = '0;
        bus.edit_weight = 1'b0;
        bus.vc_assign = '0;
        bus.weight_assign = '0;
`ifdef WRR_STATS_EN
        bus.clr_stats = 1'b0;
`endif
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic write_w(input int vc, input int w);
        bus.edit_weight = 1'b1;
        bus.vc_assign = 2'(vc);
        bus.weight_assign = 3'(w);
        tick();
        bus.edit_weight = 1'b0;
    endtask

    int rot[10] = '{0, 0, 0, 1, 2, 2, 0, 0, 0, 1};
    int sw_wo[6] = '{4, 4, 4, 4, 1, 1};
    int sw_ql[6] = '{3, 2, 1, 0, 0, 0};

    initial begin
        #1;
        do_reset();
        chk("reset_grant_valid", 32'(bus.grant_valid), 32'd0);
        chk("reset_grant_id", 32'(bus.grant_id), 32'd0);
        chk("reset_weight_out", 32'(bus.weight_out), 32'd0);
        chk("reset_quantum_left", 32'(bus.quantum_left), 32'd0);
        bus.req = 4'b1111;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("default_gv", 32'(bus.grant_valid), 32'd1);
            chk("default_id", 32'(bus.grant_id), 32'(i));
            chk("default_weight", 32'(bus.weight_out), 32'd1);
            tick();
        end

        do_reset();
        write_w(0, 3); write_w(1, 1); write_w(2, 2); write_w(3, 0);
        bus.req = 4'b1111;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("rotation_gv", 32'(bus.grant_valid), 32'd1);
            chk("rotation_id", 32'(bus.grant_id), 32'(rot[i]));
            tick();
        end

        do_reset();
        write_w(1, 5);
        bus.req = 4'b0010;
        tick();
        chk("drop_first_ql", 32'(bus.quantum_left), 32'd4);
        tick();
        chk("drop_second_ql", 32'(bus.quantum_left), 32'd3);
        bus.req = 4'b0000;
        tick();
        chk("drop_gv", 32'(bus.grant_valid), 32'd0);
        chk("drop_ql", 32'(bus.quantum_left), 32'd0);
        chk("drop_id_held", 32'(bus.grant_id), 32'd1);
        chk("drop_wo_held", 32'(bus.weight_out), 32'd5);

        do_reset();
        write_w(2, 4);
        bus.req = 4'b0100;
        write_w(2, 1);
        for (int i = 0; i < 6; i++) begin
            chk("same_edge_gv", 32'(bus.grant_valid), 32'd1);
            chk("same_edge_wo", 32'(bus.weight_out), 32'(sw_wo[i]));
            chk("same_edge_ql", 32'(bus.quantum_left), 32'(sw_ql[i]));
            tick();
        end

        do_reset();
        write_w(0, 6);
        bus.req = 4'b0001;
        tick(); tick(); tick();
        chk("async_pre_ql", 32'(bus.quantum_left), 32'd3);
        #1 reset = 1'b0;
        #1;
        chk("async_gv", 32'(bus.grant_valid), 32'd0);
        chk("async_id", 32'(bus.grant_id), 32'd0);
        chk("async_ql", 32'(bus.quantum_left), 32'd0);
        chk("async_wo", 32'(bus.weight_out), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("after_reset_wo", 32'(bus.weight_out), 32'd1);
        chk("after_reset_gv", 32'(bus.grant_valid), 32'd1);
        tick();
        chk("back_to_back_gv", 32'(bus.grant_valid), 32'd1);
        chk("back_to_back_wo", 32'(bus.weight_out), 32'd1);

`ifdef WRR_STATS_EN
        do_reset();
        write_w(1, 7);
        bus.req = 4'b0010;
        repeat (310) tick();
        chk("stats_saturate", bus.served_cnt, 32'h0000ff00);
        bus.clr_stats = 1'b1;
        tick();
        bus.clr_stats = 1'b0;
        chk("stats_clear", bus.served_cnt, 32'h0);
        tick();
        chk("stats_restart", bus.served_cnt, 32'h00000100);
`endif

        do_reset();
        for (int n = 0; n < 1500; n++) begin
            bus.req = 4'($urandom);
            bus.edit_weight = ($urandom_range(0, 3) == 0);
            bus.vc_assign = 2'($urandom);
            bus.weight_assign = 3'($urandom);
`ifdef WRR_STATS_EN
            bus.clr_stats = ($urandom_range(0, 63) == 0);
`endif
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
